// File: rtl/abh_if.sv
// ============================================================================
// Module      : abh_if
// Description : Bundle between the sequencer/low-byte stage and the
//               address-bus-high stage of the 65C02 core.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface abh_if;
  logic       CI;      // carry from the low-byte stage
  logic       pcl_co;  // carry out of the PCL increment
  logic [7:0] DB;      // data bus
  logic [3:0] op;      // high-byte operation
  logic       ld_ahh;  // load AHH from DB
  logic       ld_pc;   // load PCH from ABH + pcl_co
  logic [7:0] ADH;     // combinational high address byte
  logic [7:0] ABH;     // registered ADH
  logic [7:0] PCH;     // program counter high
  logic [7:0] AHH;     // address hold high
  logic       fix;     // page-fix cycle in progress

  // Sequencer side: drives controls, observes results
  modport master (
    output CI, pcl_co, DB, op, ld_ahh, ld_pc,
    input  ADH, ABH, PCH, AHH, fix
  );

  // Address-high stage side
  modport slave (
    input  CI, pcl_co, DB, op, ld_ahh, ld_pc,
    output ADH, ABH, PCH, AHH, fix
  );
endinterface

`default_nettype wire

// File: rtl/abh.sv
// ============================================================================
// Module      : abh
// Description : Address-bus-high stage. Forms ADH from PCH/ABH/DB/AHH plus
//               the low-byte carry, holds PCH and AHH, and inserts a single
//               page-fix cycle for deferred index/branch operations whose
//               high byte must change.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module abh (
  input  logic   clk,
  input  logic   rst_n,
  abh_if.slave   bus
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_FIX  = 1'b1
  } state_t;

  localparam logic [3:0] C_OP_PC    = 4'b0000;
  localparam logic [3:0] C_OP_ABH   = 4'b0001;
  localparam logic [3:0] C_OP_DB    = 4'b0010;
  localparam logic [3:0] C_OP_AHH   = 4'b0011;
  localparam logic [3:0] C_OP_DIDX  = 4'b0100;
  localparam logic [3:0] C_OP_DBRA  = 4'b0101;
  localparam logic [3:0] C_OP_ZP    = 4'b0110;
  localparam logic [3:0] C_OP_STK   = 4'b0111;
  localparam logic [3:0] C_OP_VEC   = 4'b1000;

  state_t     r_state;
  logic       r_fix;
  logic [7:0] r_abh;
  logic [7:0] r_pch;
  logic [7:0] r_ahh;
  logic [7:0] r_tgt;

  logic [7:0] w_adh;
  logic [7:0] w_tgt;
  logic       w_defer;
  logic [7:0] w_ci8;

  assign w_ci8 = {7'b0, bus.CI};

  // High-byte selection; in FIX the latched target overrides op and CI
  always_comb begin
    w_adh   = r_abh;
    w_tgt   = r_abh;
    w_defer = 1'b0;
    if (r_state == ST_FIX) begin
      w_adh = r_tgt;
    end else begin
      case (bus.op)
        C_OP_PC:   w_adh = r_pch + w_ci8;
        C_OP_ABH:  w_adh = r_abh + w_ci8;
        C_OP_DB:   w_adh = bus.DB + w_ci8;
        C_OP_AHH:  w_adh = r_ahh + w_ci8;
        C_OP_DIDX: begin
          w_adh   = r_ahh;
          w_tgt   = r_ahh + w_ci8;
          w_defer = 1'b1;
        end
        C_OP_DBRA: begin
          // Sign-extend the branch offset's sign bit so a backward branch
          // without carry borrows from the high byte
          w_adh   = r_abh;
          w_tgt   = r_abh + {8{bus.DB[7]}} + w_ci8;
          w_defer = 1'b1;
        end
        C_OP_ZP:   w_adh = 8'h00;
        C_OP_STK:  w_adh = 8'h01;
        C_OP_VEC:  w_adh = 8'hFF;
        default:   w_adh = r_abh;
      endcase
    end
  end

  // State machine and all high-byte registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_fix   <= 1'b0;
      r_abh   <= 8'h00;
      r_pch   <= 8'h00;
      r_ahh   <= 8'h00;
      r_tgt   <= 8'h00;
    end else begin
      r_abh <= w_adh;
      if (bus.ld_ahh) begin
        r_ahh <= bus.DB;
      end
      // Uses the pre-edge ABH, i.e. the byte currently on the bus
      if (bus.ld_pc) begin
        r_pch <= r_abh + {7'b0, bus.pcl_co};
      end
      case (r_state)
        ST_IDLE: begin
          if (w_defer && (w_tgt != w_adh)) begin
            r_tgt   <= w_tgt;
            r_state <= ST_FIX;
            r_fix   <= 1'b1;
          end else begin
            r_fix   <= 1'b0;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_fix   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.ADH = w_adh;
  assign bus.ABH = r_abh;
  assign bus.PCH = r_pch;
  assign bus.AHH = r_ahh;
  assign bus.fix = r_fix;

endmodule

`default_nettype wire

// File: tb/tb_abh.sv
// ============================================================================
// Module      : tb_abh
// Description : Directed self-checking bench for the address-bus-high stage.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_abh;

  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;

  abh_if bus ();

  abh dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [3:0] op, input logic ci, input logic [7:0] db,
                       input logic ld_ahh, input logic ld_pc, input logic pcl_co);
    bus.op     = op;
    bus.CI     = ci;
    bus.DB     = db;
    bus.ld_ahh = ld_ahh;
    bus.ld_pc  = ld_pc;
    bus.pcl_co = pcl_co;
    #1;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b0;
    drive(4'b0000, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    #11;
    chk("rst_abh", bus.ABH, 8'h00);
    chk("rst_pch", bus.PCH, 8'h00);
    chk("rst_ahh", bus.AHH, 8'h00);
    chk("rst_fix", {7'b0, bus.fix}, 8'h00);
    chk("rst_adh_op0", bus.ADH, 8'h00);
    rst_n = 1'b1;

    // Load AHH = 12
    drive(4'b0001, 1'b0, 8'h12, 1'b1, 1'b0, 1'b0);
    tick();
    chk("ld_ahh", bus.AHH, 8'h12);

    // Deferred index, no page cross
    drive(4'b0100, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    chk("didx_nc_adh", bus.ADH, 8'h12);
    tick();
    chk("didx_nc_fix", {7'b0, bus.fix}, 8'h00);
    chk("didx_nc_abh", bus.ABH, 8'h12);

    // Deferred index with page cross; garbage op during the fix cycle
    drive(4'b0100, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
    chk("didx_pc_adh", bus.ADH, 8'h12);
    tick();
    chk("didx_pc_fix1", {7'b0, bus.fix}, 8'h01);
    drive(4'b1011, 1'b0, 8'h55, 1'b0, 1'b0, 1'b0);
    chk("didx_pc_fixadh", bus.ADH, 8'h13);
    tick();
    chk("didx_pc_fix0", {7'b0, bus.fix}, 8'h00);
    chk("didx_pc_abh", bus.ABH, 8'h13);

    // Backward branch across a page: ABH=20, DB=F0, CI=0 -> 1F
    drive(4'b0010, 1'b0, 8'h20, 1'b0, 1'b0, 1'b0);
    chk("abs_adh", bus.ADH, 8'h20);
    tick();
    drive(4'b0101, 1'b0, 8'hF0, 1'b0, 1'b0, 1'b0);
    chk("bbr_adh", bus.ADH, 8'h20);
    tick();
    chk("bbr_fix", {7'b0, bus.fix}, 8'h01);
    drive(4'b0011, 1'b1, 8'hAA, 1'b0, 1'b0, 1'b0);
    chk("bbr_fixadh", bus.ADH, 8'h1F);
    tick();
    chk("bbr_abh", bus.ABH, 8'h1F);
    chk("bbr_fix0", {7'b0, bus.fix}, 8'h00);

    // Forward branch staying in page: ABH=20, DB=10, no carry
    drive(4'b0010, 1'b0, 8'h20, 1'b0, 1'b0, 1'b0);
    tick();
    drive(4'b0101, 1'b0, 8'h10, 1'b0, 1'b0, 1'b0);
    chk("fbr_adh", bus.ADH, 8'h20);
    tick();
    chk("fbr_fix", {7'b0, bus.fix}, 8'h00);
    chk("fbr_abh", bus.ABH, 8'h20);

    // Branch wrap FF -> 00
    drive(4'b0010, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b0);
    tick();
    drive(4'b0101, 1'b1, 8'h05, 1'b0, 1'b0, 1'b0);
    chk("wrap_up_adh", bus.ADH, 8'hFF);
    tick();
    chk("wrap_up_fix", {7'b0, bus.fix}, 8'h01);
    chk("wrap_up_fixadh", bus.ADH, 8'h00);
    tick();
    chk("wrap_up_abh", bus.ABH, 8'h00);

    // Branch wrap 00 -> FF, back-to-back after the previous fix
    drive(4'b0101, 1'b0, 8'h80, 1'b0, 1'b0, 1'b0);
    chk("wrap_dn_adh", bus.ADH, 8'h00);
    tick();
    chk("wrap_dn_fix", {7'b0, bus.fix}, 8'h01);
    chk("wrap_dn_fixadh", bus.ADH, 8'hFF);
    tick();
    chk("wrap_dn_abh", bus.ABH, 8'hFF);

    // PC increment across a page
    drive(4'b0010, 1'b0, 8'h3F, 1'b0, 1'b0, 1'b0);
    tick();
    drive(4'b0001, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
    tick();
    chk("pch_40", bus.PCH, 8'h40);
    drive(4'b0010, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b0);
    tick();
    drive(4'b0001, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
    tick();
    chk("pch_wrap", bus.PCH, 8'h00);
    drive(4'b0000, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
    chk("pc_restore", bus.ADH, 8'h01);

    // Constants and reserved op
    drive(4'b0110, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
    chk("const_zp", bus.ADH, 8'h00);
    drive(4'b0111, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
    chk("const_stk", bus.ADH, 8'h01);
    drive(4'b1000, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    chk("const_vec", bus.ADH, 8'hFF);
    drive(4'b1001, 1'b1, 8'h33, 1'b0, 1'b0, 1'b0);
    chk("reserved", bus.ADH, 8'hFF);
    drive(4'b0011, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
    chk("ahh_imm", bus.ADH, 8'h13);

    // Simultaneous ld_ahh with deferred index uses the old AHH
    drive(4'b0100, 1'b0, 8'h77, 1'b1, 1'b0, 1'b0);
    chk("ldahh_didx_adh", bus.ADH, 8'h12);
    tick();
    chk("ldahh_didx_fix", {7'b0, bus.fix}, 8'h00);
    chk("ldahh_didx_ahh", bus.AHH, 8'h77);
    chk("ldahh_didx_abh", bus.ABH, 8'h12);

    // Reset during FIX aborts the fix
    drive(4'b0100, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
    tick();
    chk("pre_rst_fix", {7'b0, bus.fix}, 8'h01);
    rst_n = 1'b0;
    drive(4'b0000, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    chk("midrst_fix", {7'b0, bus.fix}, 8'h00);
    chk("midrst_abh", bus.ABH, 8'h00);
    chk("midrst_pch", bus.PCH, 8'h00);
    chk("midrst_ahh", bus.AHH, 8'h00);
    chk("midrst_adh", bus.ADH, 8'h00);
    tick();
    rst_n = 1'b1;
    tick();
    chk("postrst_fix", {7'b0, bus.fix}, 8'h00);
    chk("postrst_abh", bus.ABH, 8'h00);
    chk("postrst_adh", bus.ADH, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
